// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file geometry and enable decode shared by the arbiter slice
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 16;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 4'd0;

    // Register 0 is hardwired, so its enable bit is never raised.
    function automatic logic [NUM_REGS-1:0] onehot16(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] en;
        en = '0;
        if (addr != ZERO_REG) begin
            en[addr] = 1'b1;
        end
        return en;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - requester-side read/write/response handshake bundle
interface regfile_port_arbiter_if
    import regfile_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]            rd_valid;
    logic [N_REQ-1:0]            rd_ready;
    logic [REG_ADDR_W*N_REQ-1:0] rd_addr1;
    logic [REG_ADDR_W*N_REQ-1:0] rd_addr2;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ-1:0]            rsp_ready;
    logic [DATA_W*N_REQ-1:0]     rsp_data1;
    logic [DATA_W*N_REQ-1:0]     rsp_data2;
    logic [N_REQ-1:0]            wr_valid;
    logic [N_REQ-1:0]            wr_ready;
    logic [REG_ADDR_W*N_REQ-1:0] wr_addr;
    logic [DATA_W*N_REQ-1:0]     wr_data;

    modport master (
        output rd_valid, rd_addr1, rd_addr2, rsp_ready, wr_valid, wr_addr, wr_data,
        input  rd_ready, rsp_valid, rsp_data1, rsp_data2, wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr1, rd_addr2, rsp_ready, wr_valid, wr_addr, wr_data,
        output rd_ready, rsp_valid, rsp_data1, rsp_data2, wr_ready
    );

endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// rtl/regfile_port_arbiter_rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares the 16x16 regfile's 2R/1W ports between N_REQ requesters
// Optional RF_BYPASS_EN: same-cycle write data forwarded into the read response.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    regfile_port_arbiter_if.slave bus,
    output logic [NUM_REGS-1:0] rf_read_en1,
    output logic [NUM_REGS-1:0] rf_read_en2,
    output logic [NUM_REGS-1:0] rf_write_en,
    output logic [DATA_W-1:0]   rf_wdata,
    input  logic [DATA_W-1:0]   rf_rdata1,
    input  logic [DATA_W-1:0]   rf_rdata2
);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W-1:0] rd_idx, wr_idx;
    logic [N_REQ-1:0] rd_elig, rd_gnt, wr_gnt;
    logic             rd_any, wr_any;

    logic [N_REQ-1:0]             rsp_valid_q;
    logic [N_REQ-1:0][DATA_W-1:0] rsp_d1_q, rsp_d2_q;

    logic [REG_ADDR_W-1:0] rd_a1, rd_a2, wr_a;
    logic [DATA_W-1:0]     wr_d, cap1, cap2;

    // A slot is free if empty or being drained this very cycle.
    assign rd_elig = bus.rd_valid & (~rsp_valid_q | bus.rsp_ready);

    rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_rd_arb (
        .req     (rd_elig),
        .ptr     (rd_ptr),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx),
        .any     (rd_any)
    );

    rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_wr_arb (
        .req     (bus.wr_valid),
        .ptr     (wr_ptr),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx),
        .any     (wr_any)
    );

    assign bus.rd_ready  = rd_gnt;
    assign bus.wr_ready  = wr_gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data1 = rsp_d1_q;
    assign bus.rsp_data2 = rsp_d2_q;

    assign rd_a1 = bus.rd_addr1[int'(rd_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign rd_a2 = bus.rd_addr2[int'(rd_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign wr_a  = bus.wr_addr[int'(wr_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign wr_d  = bus.wr_data[int'(wr_idx)*DATA_W +: DATA_W];

    always_comb begin
        rf_read_en1 = '0;
        rf_read_en2 = '0;
        rf_write_en = '0;
        rf_wdata    = '0;
        if (rd_any) begin
            rf_read_en1 = onehot16(rd_a1);
            rf_read_en2 = onehot16(rd_a2);
        end
        if (wr_any) begin
            rf_write_en = onehot16(wr_a);
            rf_wdata    = wr_d;
        end
    end

`ifdef RF_BYPASS_EN
    // A nonzero read address matching the granted write can only be a real write.
    always_comb begin
        cap1 = rf_rdata1;
        cap2 = rf_rdata2;
        if (wr_any && (wr_a == rd_a1)) cap1 = wr_d;
        if (wr_any && (wr_a == rd_a2)) cap2 = wr_d;
        if (rd_a1 == ZERO_REG) cap1 = '0;
        if (rd_a2 == ZERO_REG) cap2 = '0;
    end
`else
    always_comb begin
        cap1 = (rd_a1 == ZERO_REG) ? '0 : rf_rdata1;
        cap2 = (rd_a2 == ZERO_REG) ? '0 : rf_rdata2;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            rsp_valid_q <= '0;
            rsp_d1_q    <= '0;
            rsp_d2_q    <= '0;
        end else begin
            if (rd_any) begin
                rd_ptr <= (int'(rd_idx) == N_REQ - 1) ? '0 : rd_idx + 1'b1;
            end
            if (wr_any) begin
                wr_ptr <= (int'(wr_idx) == N_REQ - 1) ? '0 : wr_idx + 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (rd_gnt[i]) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_d1_q[i]    <= cap1;
                    rsp_d2_q[i]    <= cap2;
                end else if (bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - scoreboard bench for regfile_port_arbiter with a regfile model
module tb_regfile_port_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] rf_read_en1, rf_read_en2, rf_write_en, rf_wdata;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [15:0] mem [16];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] exp_r0, exp_r1;
    logic [31:0] popped;
    logic [1:0]  prev_g;

    regfile_port_arbiter_if #(.N_REQ(2)) bus ();

    regfile_port_arbiter #(.N_REQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rf_read_en1 (rf_read_en1),
        .rf_read_en2 (rf_read_en2),
        .rf_write_en (rf_write_en),
        .rf_wdata    (rf_wdata),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Undriven bitlines read as garbage so the register-0 forcing is visible.
    always_comb begin
        rf_rdata1 = 16'hDEAD;
        rf_rdata2 = 16'hDEAD;
        for (int k = 0; k < 16; k++) begin
            if (rf_read_en1[k]) rf_rdata1 = mem[k];
            if (rf_read_en2[k]) rf_rdata2 = mem[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            if (rst) mem[k] <= (k == 3) ? 16'h0007 : 16'h1000 + 16'(k);
            else if (rf_write_en[k]) mem[k] <= rf_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string nm, input logic [1:0] g);
        chk(nm, 32'(bus.rd_ready), 32'(g));
        if (g[0]) exp0.push_back(exp_r0);
        if (g[1]) exp1.push_back(exp_r1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
                if (exp0.size() == 0) chk("rsp0_unexpected", 32'(bus.rsp_valid[0]), 32'd0);
                else begin
                    popped = exp0.pop_front();
                    chk("rsp0_data", {bus.rsp_data1[15:0], bus.rsp_data2[15:0]}, popped);
                end
            end
            if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
                if (exp1.size() == 0) chk("rsp1_unexpected", 32'(bus.rsp_valid[1]), 32'd0);
                else begin
                    popped = exp1.pop_front();
                    chk("rsp1_data", {bus.rsp_data1[31:16], bus.rsp_data2[31:16]}, popped);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.rd_valid = '0; bus.rd_addr1 = '0; bus.rd_addr2 = '0; bus.rsp_ready = 2'b11;
        bus.wr_valid = '0; bus.wr_addr = '0;  bus.wr_data = '0;
        exp_r0 = '0; exp_r1 = '0; prev_g = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("idle_read_en1", 32'(rf_read_en1), 32'h0);
        chk("idle_read_en2", 32'(rf_read_en2), 32'h0);
        chk("idle_write_en", 32'(rf_write_en), 32'h0);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("idle_rsp_data1", bus.rsp_data1, 32'h0);
        chk("idle_rsp_data2", bus.rsp_data2, 32'h0);
        tick();

        bus.wr_valid = 2'b01; bus.wr_addr = 8'h05; bus.wr_data = {16'h0, 16'hBEEF};
        @(negedge clk);
        chk("wr_r5_ready", 32'(bus.wr_ready), 32'h1);
        chk("wr_r5_en", 32'(rf_write_en), 32'h0020);
        chk("wr_r5_wdata", 32'(rf_wdata), 32'hBEEF);
        tick();
        bus.wr_valid = '0;

        bus.rd_valid = 2'b01; bus.rd_addr1 = 8'h05; bus.rd_addr2 = 8'h00;
        exp_r0 = {16'hBEEF, 16'h0000};
        @(negedge clk);
        check_grant("rd_r5_gnt", 2'b01);
        chk("rd_r5_en1", 32'(rf_read_en1), 32'h0020);
        chk("rd_r5_en2", 32'(rf_read_en2), 32'h0000);
        tick();
        bus.rd_valid = 2'b10; bus.rd_addr1 = 8'h30; bus.rd_addr2 = 8'h50;
        exp_r1 = {16'h0007, 16'hBEEF};
        @(negedge clk);
        check_grant("rd_r3_gnt", 2'b10);
        tick();

        bus.rd_valid = 2'b11; bus.rd_addr1 = 8'h41; bus.rd_addr2 = 8'h62;
        exp_r0 = {16'h1001, 16'h1002};
        exp_r1 = {16'h1004, 16'h1006};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c > 0) chk("alt_rsp_valid", 32'(bus.rsp_valid), 32'(prev_g));
            prev_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            check_grant("alt_gnt", prev_g);
            tick();
        end
        bus.rd_valid = '0;
        @(negedge clk);
        chk("alt_last_valid", 32'(bus.rsp_valid), 32'(prev_g));
        tick();

        bus.rsp_ready = 2'b01; bus.rd_valid = 2'b11;
        @(negedge clk); check_grant("bp_gnt0", 2'b01); tick();
        @(negedge clk); check_grant("bp_gnt1", 2'b10); tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_grant("bp_hold_gnt", 2'b01);
            chk("bp_hold_valid", 32'(bus.rsp_valid[1]), 32'h1);
            chk("bp_hold_data", {bus.rsp_data1[31:16], bus.rsp_data2[31:16]}, 32'h1004_1006);
            tick();
        end
        bus.rsp_ready = 2'b11;
        @(negedge clk); check_grant("bp_release_gnt", 2'b10); tick();
        bus.rd_valid = '0;
        @(negedge clk);
        chk("b2b_valid", 32'(bus.rsp_valid), 32'h2);
        tick();

        bus.wr_valid = 2'b01; bus.wr_addr = 8'h03; bus.wr_data = {16'h0, 16'h1234};
        bus.rd_valid = 2'b10; bus.rd_addr1 = 8'h30; bus.rd_addr2 = 8'h30;
`ifdef RF_BYPASS_EN
        exp_r1 = {16'h1234, 16'h1234};
`else
        exp_r1 = {16'h0007, 16'h0007};
`endif
        @(negedge clk);
        chk("rw_wr_ready", 32'(bus.wr_ready), 32'h1);
        chk("rw_write_en", 32'(rf_write_en), 32'h0008);
        chk("rw_read_en1", 32'(rf_read_en1), 32'h0008);
        check_grant("rw_rd_gnt", 2'b10);
        tick();
        bus.wr_valid = '0;
        bus.rd_valid = 2'b01; bus.rd_addr1 = 8'h03; bus.rd_addr2 = 8'h00;
        exp_r0 = {16'h1234, 16'h0000};
        @(negedge clk); check_grant("rw_after_gnt", 2'b01); tick();
        bus.rd_valid = '0;

        bus.wr_valid = 2'b01; bus.wr_addr = 8'h00; bus.wr_data = {16'h0, 16'hFFFF};
        @(negedge clk);
        chk("wr_r0_ready", 32'(bus.wr_ready), 32'h1);
        chk("wr_r0_en", 32'(rf_write_en), 32'h0);
        tick();
        bus.wr_valid = '0;
        bus.rd_valid = 2'b10; bus.rd_addr1 = 8'h00; bus.rd_addr2 = 8'h00;
        exp_r1 = 32'h0;
        @(negedge clk);
        check_grant("rd_r0_gnt", 2'b10);
        chk("rd_r0_en1", 32'(rf_read_en1), 32'h0);
        tick();
        bus.rd_valid = '0;
        tick();

        bus.rsp_ready = 2'b00; bus.rd_valid = 2'b01; bus.rd_addr1 = 8'h05;
        @(negedge clk);
        chk("rst_mid_gnt", 32'(bus.rd_ready), 32'h1);
        tick();
        bus.rd_valid = '0;
        chk("rst_mid_pending", 32'(bus.rsp_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_mid_data1", bus.rsp_data1, 32'h0);
        exp0.delete();
        exp1.delete();
        tick();
        rst = 1'b0;
        bus.rsp_ready = 2'b11;
        tick();

        chk("queue0_empty", 32'(exp0.size()), 32'h0);
        chk("queue1_empty", 32'(exp1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the 16x16 register file's two read ports and single write port between N_REQ requesters, e.g. the pipeline decode stage and the debug/init loader.
- Runs independent round-robin arbitration for reads and writes.
- Drives the file's one-hot read and write enables and the write data.
- Captures read bitline data into per-requester response registers with valid/ready handshakes.
- Register 0 is hardwired to zero.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- PTR_W, $clog2(N_REQ), round-robin pointer width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rd_valid  in  N_REQ  per-requester read request.
- rd_ready  out  N_REQ  read grant; one-hot or zero.
- rd_addr1  in  4*N_REQ  read port 1 register index, packed by requester.
- rd_addr2  in  4*N_REQ  read port 2 register index, packed.
- rsp_valid  out  N_REQ  read response valid.
- rsp_ready  in  N_REQ  read response accepted.
- rsp_data1  out  16*N_REQ  port 1 read data, packed.
- rsp_data2  out  16*N_REQ  port 2 read data, packed.
- wr_valid  in  N_REQ  per-requester write request.
- wr_ready  out  N_REQ  write grant; one-hot or zero.
- wr_addr  in  4*N_REQ  write register index, packed.
- wr_data  in  16*N_REQ  write data, packed.
- rf_read_en1  out  16  one-hot read enable, read port 1.
- rf_read_en2  out  16  one-hot read enable, read port 2.
- rf_write_en  out  16  one-hot write enable.
- rf_wdata  out  16  write data to all registers.
- rf_rdata1  in  16  read port 1 bitline value.
- rf_rdata2  in  16  read port 2 bitline value.

Behaviour:
- Reset (async):
  - rd_ptr and wr_ptr = 0.
  - rsp_valid = 0 and rsp_data* = 0x0000 for all requesters.
  - Outstanding responses are dropped; a reset mid-transfer loses them.
  - rf_* enables are 0 whenever no grant exists.
- Handshake:
  - A requester holds valid and its payload stable until it sees ready.
  - Transfer occurs on any cycle with valid & ready.
  - ready is combinational from valid and state.
- Read eligibility:
  - Requester i is eligible when rd_valid[i] and its response slot is free, i.e. rsp_valid[i]==0, or rsp_valid[i] & rsp_ready[i] in the same cycle.
- Read arbitration:
  - Grant the first eligible requester scanning upward from rd_ptr, wrapping modulo N_REQ.
  - On a grant, rd_ptr <= (granted+1) mod N_REQ; with no grant, rd_ptr holds.
- Read access:
  - In the grant cycle, rf_read_en1/2 = onehot(addr1/addr2), combinationally.
  - A bit-0 enable is never driven.
- Read response:
  - At the next posedge, rsp_data*[i] captures rf_rdata*, forced to 0x0000 where the address is 0, and rsp_valid[i] <= 1.
  - Latency: grant cycle + 1.
  - Response data holds stable until rsp_ready.
  - rsp_valid clears on acceptance unless a new read for the same requester is granted in that same cycle (back-to-back).
- Write arbitration and access:
  - Separate round-robin on wr_ptr with the same rules; no slot condition.
  - rf_write_en = onehot(wr_addr of grantee) in the grant cycle; rf_wdata = its wr_data; the file captures at the posedge.
  - A write to register 0 is granted (wr_ready=1) but rf_write_en stays 0.
- Reads and writes are independent:
  - One read grant and one write grant may occur in the same cycle, to the same or different requesters.
- Same-cycle read and write of the same nonzero register:
  - The response carries the old value unless RF_BYPASS_EN is defined.
- rf_read_en1 and rf_read_en2 may select the same register.

Optional Feature:
- RF_BYPASS_EN defined:
  - Per read port, if a write is granted in the same cycle with wr_addr == that port's read address (nonzero), the captured response uses the granted wr_data instead of rf_rdata.
  - This gives write-before-read semantics.
- RF_BYPASS_EN undefined:
  - No comparators; the response always reflects rf_rdata, i.e. pre-write contents.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W=4, DATA_W=16, NUM_REGS=16, ZERO_REG=4'd0.
  - Function onehot16(addr) returning the decoded enable.
- Sub-module rr_arbiter (parameter N; inputs req, ptr; outputs gnt one-hot, gnt_idx, any), instantiated twice: read and write.
- Response registers and pointer updates live in the top.

Test Plan:
- Reset then idle: all rf_* enables = 0, rsp_valid = 0, rsp_data = 0x0000; assert rst mid-response -> rsp_valid drops immediately (async).
- Req0 writes R5=0xBEEF (wr_ready0=1, rf_write_en=0x0020), then reads R5,R0 -> rf_read_en1=0x0020, rf_read_en2=0x0000; next cycle rsp_data1=0xBEEF, rsp_data2=0x0000.
- Both requesters hold rd_valid for 6 cycles with rsp_ready=1 -> grants alternate 0,1,0,1,0,1 and each rsp_valid follows its grant by 1 cycle.
- Req1 rsp_ready=0 for 4 cycles while rd_valid1 stays high -> rd_ready1=0 throughout, rsp_data1 stays stable, req0 receives all grants; release -> req1 granted the next cycle.
- Req0 writes R3=0x1234 and req1 reads R3 (old value 0x0007) in the same cycle -> response 0x0007 without RF_BYPASS_EN, 0x1234 with it; a following read returns 0x1234.
- Write to R0 with 0xFFFF -> wr_ready=1, rf_write_en=0; a subsequent read of R0 returns 0x0000.
